// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - state encoding and default sizing shared by the clock period monitor
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_LOCK_N = 4;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchronizer for a single asynchronous bit
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_period_mon.sv
// rtl/clk_period_mon.sv - measures high/low durations of a divided clock and tracks lock against an expected half-period
module clk_period_mon
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_N      = DEF_LOCK_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_half,
  input  logic [CNT_W-1:0] tol,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             hi_valid,
  output logic             lo_valid,
  output logic             lock,
  output logic             err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int               LW        = $clog2(LOCK_N + 1);
  localparam logic [LW-1:0]    LOCK_FULL = LW'(LOCK_N);

  state_t           state, state_next;
  logic             s, s_d, rise, fall;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] high_next, low_next;
  logic [LW-1:0]    lock_cnt, lock_cnt_next;
  logic             hi_valid_next, lo_valid_next, err_next, timeout_next;
  logic             meas;
  logic [CNT_W:0]   diff;
  logic             in_tol;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .q    (s)
  );

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign lock = (lock_cnt == LOCK_FULL);

  // One extra bit keeps the deviation exact when exp_half sits near the top of the range
  always_comb begin
    if (cnt >= exp_half) diff = {1'b0, cnt} - {1'b0, exp_half};
    else                 diff = {1'b0, exp_half} - {1'b0, cnt};
  end
  assign in_tol = (diff <= {1'b0, tol});

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    lock_cnt_next = lock_cnt;
    high_next     = high_cnt;
    low_next      = low_cnt;
    hi_valid_next = 1'b0;
    lo_valid_next = 1'b0;
    err_next      = err;
    timeout_next  = timeout;
    meas          = 1'b0;
    if (!en) begin
      state_next    = IDLE;
      cnt_next      = '0;
      lock_cnt_next = '0;
      err_next      = 1'b0;
      timeout_next  = 1'b0;
    end else begin
      case (state)
        IDLE: state_next = WAIT_EDGE;
        WAIT_EDGE: begin
          if (rise) begin
            state_next = MEAS_HIGH;
            cnt_next   = CNT_W'(1);
          end else if (fall) begin
            state_next = MEAS_LOW;
            cnt_next   = CNT_W'(1);
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_next     = cnt;
            hi_valid_next = 1'b1;
            cnt_next      = CNT_W'(1);
            state_next    = MEAS_LOW;
            meas          = 1'b1;
          end else if (cnt == CNT_MAX) begin
            timeout_next  = 1'b1;
            lock_cnt_next = '0;
            state_next    = WAIT_EDGE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            low_next      = cnt;
            lo_valid_next = 1'b1;
            cnt_next      = CNT_W'(1);
            state_next    = MEAS_HIGH;
            meas          = 1'b1;
          end else if (cnt == CNT_MAX) begin
            timeout_next  = 1'b1;
            lock_cnt_next = '0;
            state_next    = WAIT_EDGE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (meas) begin
      if (in_tol) begin
        if (lock_cnt != LOCK_FULL) lock_cnt_next = lock_cnt + LW'(1);
      end else begin
        lock_cnt_next = '0;
        if (lock) err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_d      <= 1'b0;
      cnt      <= '0;
      lock_cnt <= '0;
      high_cnt <= '0;
      low_cnt  <= '0;
      hi_valid <= 1'b0;
      lo_valid <= 1'b0;
      err      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      s_d      <= s;
      cnt      <= cnt_next;
      lock_cnt <= lock_cnt_next;
      high_cnt <= high_next;
      low_cnt  <= low_next;
      hi_valid <= hi_valid_next;
      lo_valid <= lo_valid_next;
      err      <= err_next;
      timeout  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_clk_period_mon.sv
// tb/tb_clk_period_mon.sv - self-checking bench for clk_period_mon
module tb_clk_period_mon;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sig_in = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] exp_half = 16'd5;
  logic [W-1:0] tol = 16'd0;
  logic [W-1:0] high_cnt, low_cnt;
  logic         hi_valid, lo_valid, lock, err, timeout;

  logic         sig2 = 1'b0;
  logic         en2 = 1'b0;
  logic [3:0]   exp2 = 4'd5;
  logic [3:0]   tol2 = 4'd0;
  logic [3:0]   high2, low2;
  logic         hv2, lv2, lock2, err2, to2;

  int n_checks = 0;
  int n_pass = 0;
  int hq[$];
  int lq[$];
  int e_hi, e_lo;
  int pulses2 = 0;

  typedef struct {
    int           hi;
    int           lo;
    int           reps;
    logic [W-1:0] eh;
    logic [W-1:0] t;
    logic         lock_e;
    logic         err_e;
  } vec_t;

  vec_t vecs[11];

  clk_period_mon #(.CNT_W(W), .SYNC_STAGES(2), .LOCK_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en),
    .exp_half(exp_half), .tol(tol),
    .high_cnt(high_cnt), .low_cnt(low_cnt),
    .hi_valid(hi_valid), .lo_valid(lo_valid),
    .lock(lock), .err(err), .timeout(timeout)
  );

  clk_period_mon #(.CNT_W(4), .SYNC_STAGES(2), .LOCK_N(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .sig_in(sig2), .en(en2),
    .exp_half(exp2), .tol(tol2),
    .high_cnt(high2), .low_cnt(low2),
    .hi_valid(hv2), .lo_valid(lv2),
    .lock(lock2), .err(err2), .timeout(to2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic phase(input logic v, input int n, input bit push);
    sig_in = v;
    if (push) begin
      if (v) hq.push_back(n);
      else   lq.push_back(n);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    en = 1'b0;
    sig_in = 1'b0;
    repeat (6) @(posedge clk);
    #1 en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    sig_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high_cnt"}, high_cnt, 0);
    chk({tag, "_low_cnt"},  low_cnt,  0);
    chk({tag, "_hi_valid"}, hi_valid, 0);
    chk({tag, "_lo_valid"}, lo_valid, 0);
    chk({tag, "_lock"},     lock,     0);
    chk({tag, "_err"},      err,      0);
    chk({tag, "_timeout"},  timeout,  0);
  endtask

  // Scoreboard: every reported duration must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (hi_valid || lo_valid) chk("valid_exclusive", hi_valid & lo_valid, 0);
      if (hi_valid) begin
        chk("hi_expected", hq.size() > 0, 1);
        if (hq.size() > 0) begin
          e_hi = hq.pop_front();
          chk("high_cnt", high_cnt, e_hi);
        end
      end
      if (lo_valid) begin
        chk("lo_expected", lq.size() > 0, 1);
        if (lq.size() > 0) begin
          e_lo = lq.pop_front();
          chk("low_cnt", low_cnt, e_lo);
        end
      end
    end
    if (hv2 || lv2) pulses2++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;

    vecs = '{
      '{5, 5, 4, 16'd5,     16'd0,     1'b1, 1'b0},
      '{4, 6, 4, 16'd5,     16'd1,     1'b1, 1'b0},
      '{4, 6, 4, 16'd5,     16'd0,     1'b0, 1'b0},
      '{3, 3, 3, 16'd3,     16'd0,     1'b1, 1'b0},
      '{7, 2, 4, 16'd7,     16'd0,     1'b0, 1'b0},
      '{8, 8, 3, 16'd6,     16'd2,     1'b1, 1'b0},
      '{9, 9, 3, 16'd6,     16'd2,     1'b0, 1'b0},
      '{5, 5, 3, 16'hFFFF,  16'hFFF0,  1'b0, 1'b0},
      '{5, 5, 3, 16'hFFFF,  16'hFFFA,  1'b1, 1'b0},
      '{5, 5, 3, 16'd0,     16'd4,     1'b0, 1'b0},
      '{5, 5, 3, 16'd0,     16'd5,     1'b1, 1'b0}
    };

    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      exp_half = vecs[i].eh;
      tol      = vecs[i].t;
      restart();
      for (int r = 0; r < vecs[i].reps; r++) begin
        phase(1'b1, vecs[i].hi, 1'b1);
        phase(1'b0, vecs[i].lo, 1'b1);
      end
      drain();
      chk($sformatf("vec%0d_lock", i), lock, vecs[i].lock_e);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err_e);
      chk($sformatf("vec%0d_timeout", i), timeout, 0);
    end

    // Lock acquisition count, then a stretched high period while locked
    exp_half = 16'd5;
    tol = 16'd1;
    restart();
    phase(1'b1, 5, 1'b1);
    phase(1'b0, 5, 1'b1);
    phase(1'b1, 5, 1'b1);
    phase(1'b0, 5, 1'b1);
    chk("lock_after_3", lock, 0);
    phase(1'b1, 5, 1'b1);
    chk("lock_after_4", lock, 1);
    phase(1'b0, 5, 1'b1);
    phase(1'b1, 8, 1'b1);
    phase(1'b0, 5, 1'b1);
    chk("stretch_lock", lock, 0);
    chk("stretch_err", err, 1);
    phase(1'b1, 5, 1'b1);
    phase(1'b0, 5, 1'b1);
    phase(1'b1, 5, 1'b1);
    phase(1'b0, 5, 1'b1);
    chk("relock_lock", lock, 1);
    chk("relock_err_sticky", err, 1);

    // One-cycle enable drop in the middle of a high period
    sig_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1;
    chk("endrop_lock", lock, 0);
    chk("endrop_err", err, 0);
    chk("endrop_timeout", timeout, 0);
    chk("endrop_high_hold", high_cnt, 5);
    phase(1'b0, 5, 1'b1);
    phase(1'b1, 5, 1'b1);
    phase(1'b0, 5, 1'b1);
    phase(1'b1, 5, 1'b1);

    // Asynchronous reset in the middle of a low period
    sig_in = 1'b0;
    repeat (5) @(posedge clk);
    chk("prereset_lock", lock, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tol = 16'd0;
    for (int r = 0; r < 4; r++) begin
      phase(1'b1, 5, 1'b1);
      phase(1'b0, 5, 1'b1);
    end
    drain();
    chk("postreset_lock", lock, 1);
    chk("postreset_high", high_cnt, 5);
    chk("postreset_low", low_cnt, 5);

    // Counter saturation on a 4-bit instance
    en2 = 1'b1;
    repeat (6) @(posedge clk);
    #1 sig2 = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("small_timeout_early", to2, 0);
    repeat (13) @(posedge clk);
    #1 chk("small_timeout_set", to2, 1);
    chk("small_no_pulses", pulses2, 0);
    chk("small_lock", lock2, 0);
    sig2 = 1'b0;
    repeat (6) @(posedge clk);
    #1 sig2 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (hv2 || lv2) begin
        seen = 1'b1;
        chk("small_lo_valid", lv2, 1);
        chk("small_low_cnt", low2, 6);
      end
    end
    chk("small_pulse_seen", seen, 1);
    chk("small_timeout_sticky", to2, 1);

    chk("hq_drained", hq.size(), 0);
    chk("lq_drained", lq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_period_mon.md
CLK_PERIOD_MON -- requirements
Module: clk_period_mon

Interface
REQ-001 Parameter CNT_W, default 16, width of the period counters and results.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_in (minimum 2).
REQ-003 Parameter LOCK_N, default 4, consecutive in-tolerance half-periods required for lock.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sig_in  input  1  monitored divided clock, asynchronous to clk.
REQ-007 en  input  1  monitor enable; low forces IDLE and clears lock, err and timeout.
REQ-008 exp_half  input  CNT_W  expected half-period in clk cycles, sampled every comparison.
REQ-009 tol  input  CNT_W  allowed absolute deviation from exp_half.
REQ-010 high_cnt  output  CNT_W  last measured high duration in clk cycles.
REQ-011 low_cnt  output  CNT_W  last measured low duration in clk cycles.
REQ-012 hi_valid  output  1  one-cycle pulse when high_cnt updates.
REQ-013 lo_valid  output  1  one-cycle pulse when low_cnt updates.
REQ-014 lock  output  1  high while the last LOCK_N measurements were all in tolerance.
REQ-015 err  output  1  sticky: an out-of-tolerance measurement occurred while locked.
REQ-016 timeout  output  1  sticky: no edge within 2^CNT_W-1 cycles.

Function
REQ-017 sig_in passes through SYNC_STAGES flops; edge detection compares the synchronized level s with its one-cycle-delayed copy s_d.
REQ-018 States: IDLE, WAIT_EDGE, MEAS_HIGH, MEAS_LOW.
REQ-019 IDLE -> WAIT_EDGE when en=1; any state -> IDLE when en=0 (same cycle, registered).
REQ-020 WAIT_EDGE: rising edge (s=1, s_d=0) -> MEAS_HIGH, falling edge -> MEAS_LOW; counter loads 1; no result is produced for the partial first period.
REQ-021 MEAS_HIGH/MEAS_LOW: counter increments by 1 each cycle the level is unchanged; counter saturates at 2^CNT_W-1.
REQ-022 On falling edge in MEAS_HIGH: high_cnt <= counter, hi_valid pulses next cycle, counter reloads 1, -> MEAS_LOW; rising edge in MEAS_LOW symmetric for low_cnt/lo_valid.
REQ-023 A signal toggling synchronously every K clk cycles yields high_cnt = low_cnt = K.
REQ-024 In-tolerance test: |counter - exp_half| <= tol, computed at CNT_W+1 bits with no wrap.
REQ-025 In-tolerance result: lock counter increments, saturating at LOCK_N; lock=1 when it equals LOCK_N.
REQ-026 Out-of-tolerance result: lock counter clears, lock drops the next cycle; err sets if lock was 1 at that result.
REQ-027 Counter reaching saturation: timeout sets, lock counter clears, state -> WAIT_EDGE, no valid pulse.
REQ-028 Edge in the same cycle as en falling: ignored, en takes priority.
REQ-029 hi_valid and lo_valid never assert in the same cycle.
REQ-030 high_cnt/low_cnt hold their values across en=0; only reset clears them.

Reset
REQ-031 rst_n=0 asynchronously forces state IDLE, synchronizer flops 0, counters 0, and all outputs 0.
REQ-032 Reset release mid-period: first measurement after release discarded per REQ-020.

Structure
REQ-033 Package clk_mon_pkg holds the state enumeration and default CNT_W/LOCK_N constants.
REQ-034 One sub-module, bit_sync (parameterized SYNC_STAGES flop chain, async active-low reset); all else in clk_period_mon.

Verification
REQ-035 sig_in toggling every 5 clk cycles, exp_half=5, tol=0 -> high_cnt=low_cnt=5, lock=1 after the 4th valid pulse, err=0.
REQ-036 Locked at 5, one high period stretched to 8, tol=1 -> hi_valid with high_cnt=8, lock drops, err=1 and stays 1 after lock re-acquires.
REQ-037 CNT_W=4, sig_in held constant after WAIT_EDGE edge -> timeout=1 after 15 cycles, no valid pulses, state returns to WAIT_EDGE.
REQ-038 en=0 for one cycle while locked -> lock, err, timeout cleared; high_cnt retains 5; first post-enable period discarded.
REQ-039 rst_n asserted mid MEAS_LOW, asynchronous to clk -> all outputs 0 immediately; after release, first complete period measured correctly.
REQ-040 Period alternating 4/6 with exp_half=5, tol=1 -> lock holds; with tol=0 -> lock never asserts.
